linebuffer_window_reader: RTL



---
 rtl/linebuffer_window_reader.sv | 87 ++++++++
 1 files changed

// File: rtl/linebuffer_window_reader.sv
// linebuffer_window_reader: four-row rotating line buffer emitting 3x3 pixel windows.
// Define WINDOW_EOL_EN to add o_eol, flagging the last window of each row.
module linebuffer_window_reader #(
  parameter int DW = 12,
  parameter int RL = 640
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [DW-1:0]   i_data,
  input  logic            i_wr_data,
  output logic            o_wr_ready,
  output logic [9*DW-1:0] o_data,
  output logic            o_valid,
  input  logic            i_ready
`ifdef WINDOW_EOL_EN
  ,
  output logic            o_eol
`endif
);
  localparam int AW = (RL > 1) ? $clog2(RL) : 1;
  typedef enum logic [1:0] {IDLE, STREAM, RETIRE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0] wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, s1, s2;
  logic [2:0] rows_q, rows_d;
  logic [9*DW-1:0] data_q, data_d, win;
  logic valid_q, valid_d, wr_en, row_done, issue, last, retire;
  logic [DW-1:0] mem [4][RL];
  always_comb begin
    wr_en = i_wr_data && rows_q != 3'd4;
    row_done = wr_en && wptr_q == AW'(RL - 1);
    wptr_d = row_done ? '0 : wr_en ? wptr_q + AW'(1) : wptr_q;
    wr_sel_d = row_done ? wr_sel_q + 2'd1 : wr_sel_q;
    issue = state_q == STREAM && (!valid_q || i_ready);
    last = rptr_q == AW'(RL - 3);
    retire = state_q == RETIRE;
    rows_d = rows_q + 3'(row_done) - 3'(retire);
    rd_sel_d = retire ? rd_sel_q + 2'd1 : rd_sel_q;
    rptr_d = issue ? (last ? '0 : rptr_q + AW'(1)) : rptr_q;
    state_d = state_q == IDLE ? (rows_q >= 3'd3 ? STREAM : IDLE) :
              state_q == STREAM ? (issue && last ? RETIRE : STREAM) :
              (rows_d >= 3'd3 ? STREAM : IDLE);
    s1 = rd_sel_q + 2'd1;
    s2 = rd_sel_q + 2'd2;
    win = {mem[rd_sel_q][rptr_q], mem[rd_sel_q][rptr_q + AW'(1)], mem[rd_sel_q][rptr_q + AW'(2)],
           mem[s1][rptr_q], mem[s1][rptr_q + AW'(1)], mem[s1][rptr_q + AW'(2)],
           mem[s2][rptr_q], mem[s2][rptr_q + AW'(1)], mem[s2][rptr_q + AW'(2)]};
    valid_d = issue ? 1'b1 : i_ready ? 1'b0 : valid_q;
    data_d = issue ? win : data_q;
  end
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_sel_q][wptr_q] <= i_data;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      wr_sel_q <= '0;
      rd_sel_q <= '0;
      rows_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      rows_q <= rows_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  end
`ifdef WINDOW_EOL_EN
  logic eol_q, eol_d;
  always_comb eol_d = issue ? last : eol_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) eol_q <= 1'b0;
    else eol_q <= eol_d;
  end
  assign o_eol = eol_q;
`endif
  assign o_wr_ready = rows_q != 3'd4;
  assign o_data = data_q;
  assign o_valid = valid_q;
endmodule
